// File: rtl/gumnut_ctrl_pkg.sv
// gumnut_ctrl_pkg: shared state, opcode-class, ALU and PC-operation codes for the Gumnut sequencer
package gumnut_ctrl_pkg;
  typedef enum logic [2:0] {
    S_FETCH     = 3'd0,
    S_DECODE    = 3'd1,
    S_EXECUTE   = 3'd2,
    S_MEM       = 3'd3,
    S_WRITEBACK = 3'd4,
    S_INT       = 3'd5,
    S_WAIT      = 3'd6
  } state_t;
  typedef enum logic [2:0] {C_NONE, C_MEM, C_SHIFT, C_ARITH, C_JUMP, C_BRANCH, C_MISC} op_class_t;
  localparam logic [1:0] F_LDM = 2'b00, F_STM = 2'b01, F_INP = 2'b10, F_OUT = 2'b11;
  localparam logic [2:0] F_RET = 3'b000, F_RETI = 3'b001, F_ENAI = 3'b010, F_DISI = 3'b011;
  localparam logic [2:0] F_WAIT = 3'b100, F_STBY = 3'b101;
  localparam logic [3:0] ALU_NONE = 4'b0000, ALU_ADD = 4'b0001, ALU_SUB = 4'b0011, ALU_AND = 4'b0010;
  localparam logic [3:0] ALU_OR = 4'b0110, ALU_XOR = 4'b0100, ALU_MASK = 4'b0101;
  localparam logic [3:0] PC_INC = 4'b0000, PC_JMP = 4'b1000, PC_RET = 4'b1001, PC_INT = 4'b1010;
  localparam logic [3:0] PC_TRAP = 4'b1111;
  localparam logic [1:0] PC_BR = 2'b01;
  localparam logic [1:0] MUX_ALU = 2'b00, MUX_MEM = 2'b01, MUX_PORT = 2'b10;
  function automatic op_class_t op_class(input logic [6:0] op);
    return op[6:5] == 2'b10 ? C_MEM : op[6:4] == 3'b110 ? C_SHIFT : op[6:3] == 4'b1110 ? C_ARITH :
           op[6:2] == 5'b11110 ? C_JUMP : op[6:1] == 6'b111110 ? C_BRANCH :
           op == 7'b1111110 ? C_MISC : C_NONE;
  endfunction
  function automatic logic [3:0] alu_code(input logic [2:0] fn);
    return fn[2:1] == 2'b00 ? ALU_ADD : fn[2:1] == 2'b01 ? ALU_SUB : fn == 3'b100 ? ALU_AND :
           fn == 3'b101 ? ALU_OR : fn == 3'b110 ? ALU_XOR : ALU_MASK;
  endfunction
endpackage

// File: rtl/gumnut_ctrl_seq_irq_prio.sv
// gumnut_irq_prio: masked priority encoder, lowest-index active channel wins
module gumnut_irq_prio #(
  parameter int NUM_IRQ = 4,
  parameter int IRQ_W = 2
) (
  input  logic [NUM_IRQ-1:0] irq,
  input  logic [NUM_IRQ-1:0] mask,
  output logic               valid,
  output logic [IRQ_W-1:0]   idx,
  output logic [NUM_IRQ-1:0] onehot
);
  logic [NUM_IRQ-1:0] act;
  assign act = irq & ~mask;
  always_comb begin
    valid = |act;
    onehot = act & (-act);
    idx = '0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) idx = act[i] ? IRQ_W'(i) : idx;
  end
endmodule

// File: rtl/gumnut_ctrl_seq.sv
// gumnut_ctrl_seq: Moore control sequencer with prioritised interrupts, WAIT state and bus-timeout trap
module gumnut_ctrl_seq
  import gumnut_ctrl_pkg::*;
#(
  parameter int NUM_IRQ = 4,
  parameter int TIMEOUT = 15,
  parameter int IRQ_W = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cen,
  input  logic [6:0]         op_i,
  input  logic [2:0]         func_i,
  input  logic               inst_ack_i,
  input  logic               data_ack_i,
  input  logic [NUM_IRQ-1:0] irq_i,
  input  logic [NUM_IRQ-1:0] irq_mask_i,
  output logic               inst_stb_o,
  output logic               inst_cyc_o,
  output logic               data_stb_o,
  output logic               data_cyc_o,
  output logic               data_we_o,
  output logic               op2_o,
  output logic               alu_en_o,
  output logic               flag_en_o,
  output logic               reg_wr_o,
  output logic [3:0]         alu_op_o,
  output logic [1:0]         reg_mux_o,
  output logic               port_we_o,
  output logic               pc_en_o,
  output logic [3:0]         pc_oper_o,
  output logic               push_o,
  output logic               pop_o,
  output logic               int_o,
  output logic [NUM_IRQ-1:0] int_ack_o,
  output logic [IRQ_W-1:0]   int_vec_o,
  output logic               bus_err_o,
  output logic [2:0]         state_o
);
  state_t state, state_nx;
  op_class_t cls;
  logic ie, ie_save, trap, ie_eff, pend, timeout, bus_st, ack_cur, done_dec;
  logic irq_valid;
  logic is_ldm, is_stm, is_inp, is_out, is_ret, is_reti, is_enai, is_disi, is_wait;
  logic st_fe, st_de, st_ex, st_me, st_wb, st_in;
  logic [7:0] cnt;
  logic [IRQ_W-1:0] irq_idx, vec;
  logic [NUM_IRQ-1:0] irq_oh, ack_q;
  gumnut_irq_prio #(.NUM_IRQ(NUM_IRQ), .IRQ_W(IRQ_W)) u_prio (
    .irq(irq_i), .mask(irq_mask_i), .valid(irq_valid), .idx(irq_idx), .onehot(irq_oh)
  );
  always_comb begin
    cls = op_class(op_i);
    is_ldm = cls == C_MEM && func_i[1:0] == F_LDM;
    is_stm = cls == C_MEM && func_i[1:0] == F_STM;
    is_inp = cls == C_MEM && func_i[1:0] == F_INP;
    is_out = cls == C_MEM && func_i[1:0] == F_OUT;
    is_ret = cls == C_MISC && func_i == F_RET;
    is_reti = cls == C_MISC && func_i == F_RETI;
    is_enai = cls == C_MISC && func_i == F_ENAI;
    is_disi = cls == C_MISC && func_i == F_DISI;
    is_wait = cls == C_MISC && (func_i == F_WAIT || func_i == F_STBY);
    done_dec = cls == C_JUMP || cls == C_BRANCH || is_ret || is_reti || is_enai || is_disi;
    // enai/disi/reti take effect before the pend check of their own DECODE cycle
    ie_eff = state != S_DECODE ? ie : is_enai ? 1'b1 : is_disi ? 1'b0 : is_reti ? ie_save : ie;
    pend = ie_eff && irq_valid;
    bus_st = state == S_FETCH || state == S_MEM;
    ack_cur = state == S_FETCH ? inst_ack_i : data_ack_i;
    timeout = bus_st && !ack_cur && cnt == 8'(TIMEOUT - 1);
    case (state)
      S_FETCH:     state_nx = inst_ack_i ? S_DECODE : S_FETCH;
      S_DECODE:    state_nx = done_dec ? (pend ? S_INT : S_FETCH) : is_wait ? S_WAIT : S_EXECUTE;
      S_EXECUTE:   state_nx = (is_ldm || is_stm) ? S_MEM : S_WRITEBACK;
      S_MEM:       state_nx = !data_ack_i ? S_MEM : is_stm ? (pend ? S_INT : S_FETCH) : S_WRITEBACK;
      S_WRITEBACK: state_nx = pend ? S_INT : S_FETCH;
      S_WAIT:      state_nx = pend ? S_INT : S_WAIT;
      default:     state_nx = S_FETCH;
    endcase
    state_nx = timeout ? S_INT : state_nx;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_FETCH;
      ie <= 1'b0;
      ie_save <= 1'b0;
      trap <= 1'b0;
      cnt <= '0;
      vec <= '0;
      ack_q <= '0;
    end else if (cen) begin
      state <= state_nx;
      cnt <= (state_nx != state || ack_cur || !bus_st) ? '0 : cnt + 8'd1;
      if (state_nx == S_INT && state != S_INT) begin
        ie <= 1'b0;
        ie_save <= ie_eff;
        trap <= timeout;
        ack_q <= timeout ? '0 : irq_oh;
        if (!timeout) vec <= irq_idx;
      end else begin
        ie <= ie_eff;
      end
    end
  end
  always_comb begin
    st_fe = !rst && state == S_FETCH;
    st_de = !rst && state == S_DECODE;
    st_ex = !rst && state == S_EXECUTE;
    st_me = !rst && state == S_MEM;
    st_wb = !rst && state == S_WRITEBACK;
    st_in = !rst && state == S_INT;
    inst_stb_o = st_fe;
    inst_cyc_o = st_fe;
    data_stb_o = st_me;
    data_cyc_o = st_me;
    data_we_o = st_me && is_stm;
    op2_o = st_ex && (cls == C_ARITH || cls == C_SHIFT);
    alu_en_o = op2_o;
    flag_en_o = op2_o;
    alu_op_o = (!rst && cls == C_ARITH) ? alu_code(func_i) : ALU_NONE;
    port_we_o = st_ex && is_out;
    reg_wr_o = st_wb;
    reg_mux_o = !st_wb ? MUX_ALU : is_ldm ? MUX_MEM : is_inp ? MUX_PORT : MUX_ALU;
    pc_en_o = st_wb || st_in || (st_de && (cls == C_JUMP || cls == C_BRANCH || is_ret || is_reti));
    pc_oper_o = st_in ? (trap ? PC_TRAP : PC_INT) : !st_de ? PC_INC :
                cls == C_BRANCH ? {PC_BR, func_i[1:0]} : cls == C_JUMP ? PC_JMP :
                (is_ret || is_reti) ? PC_RET : PC_INC;
    push_o = st_in || (st_de && cls == C_JUMP && op_i[1]);
    pop_o = st_de && (is_ret || is_reti);
    int_o = st_in;
    int_ack_o = st_in ? ack_q : '0;
    int_vec_o = rst ? '0 : vec;
    bus_err_o = st_in && trap;
    state_o = rst ? S_FETCH : state;
  end
endmodule

// File: doc/gumnut_ctrl_seq.md
# gumnut_ctrl_seq

Parametrised successor to the Gumnut control sequencer. It is a Moore-style state machine that steps each instruction through fetch, decode, execute, memory and writeback, and drives the processing unit, PC unit and the Wishbone-style instruction and data buses. Compared with the previous sequencer it adds:
- NUM_IRQ prioritised, maskable interrupt channels with a vector number and per-channel acknowledge;
- an internal interrupt-enable flag;
- a WAIT state for the wait/stby instructions;
- a configurable bus-timeout trap.

## Interface
Parameters:
- NUM_IRQ, 4: number of interrupt request channels (1..16).
- TIMEOUT, 15: cycles without ack in FETCH or MEM before a bus-error trap (1..255).
- IRQ_W, $clog2(NUM_IRQ) (minimum 1): width of the vector number.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset; synchronous, active-high; also sampled when cen=0.
- cen  in  1  clock enable; state, counter and registers advance only when cen=1.
- op_i  in  7  opcode field from the instruction register.
- func_i  in  3  function field.
- inst_ack_i  in  1  instruction memory ack.
- data_ack_i  in  1  data memory ack.
- irq_i  in  NUM_IRQ  level interrupt requests.
- irq_mask_i  in  NUM_IRQ  1 = channel masked.
- inst_stb_o, inst_cyc_o  out  1  instruction bus strobe/cycle.
- data_stb_o, data_cyc_o, data_we_o  out  1  data bus strobe, cycle and write.
- op2_o, alu_en_o, flag_en_o, reg_wr_o  out  1  processing unit enables.
- alu_op_o  out  4  ALU operation.
- reg_mux_o  out  2  register write source: 00 ALU, 01 data memory, 10 port.
- port_we_o  out  1  output port write.
- pc_en_o  out  1  PC update.
- pc_oper_o  out  4  PC operation.
- push_o, pop_o  out  1  return-stack push/pop.
- int_o  out  1  interrupt entry (save PC and flags).
- int_ack_o  out  NUM_IRQ  one-hot acknowledge of the serviced channel.
- int_vec_o  out  IRQ_W  registered number of the last serviced channel.
- bus_err_o  out  1  bus-timeout trap indication.
- state_o  out  3  current state, for debug.

## Operation
Opcode decode:
- memory: op_i[6:5]=10; func_i[1:0]: 00 ldm, 01 stm, 10 inp, 11 out.
- shift: op_i[6:4]=110.
- arith: op_i[6:3]=1110.
- jump: op_i[6:2]=11110; op_i[1]: 0 jmp, 1 jsb.
- branch: op_i[6:1]=111110.
- misc: op_i=1111110; func_i: 000 ret, 001 reti, 010 enai, 011 disi, 100 wait, 101 stby.

States are FETCH, DECODE, EXECUTE, MEM, WRITEBACK, INT and WAIT. "pend" is true when ie=1 and |(irq_i & ~irq_mask_i).

Transitions:
- FETCH -> DECODE on inst_ack_i.
- DECODE:
  - jump, branch and misc ret/reti/enai/disi complete here. They go to INT if pend (evaluated after the enai/disi/reti effect), else to FETCH.
  - wait and stby go to WAIT.
  - All other instructions go to EXECUTE.
- EXECUTE: ldm/stm -> MEM; all others -> WRITEBACK.
- MEM:
  - stm with data_ack_i -> INT if pend, else FETCH.
  - ldm with data_ack_i -> WRITEBACK.
  - Otherwise stay in MEM.
- WRITEBACK -> INT if pend, else FETCH.
- INT -> FETCH.
- WAIT -> INT if pend; otherwise stay in WAIT.

Interrupt-enable flag (ie):
- Reset value 0.
- enai sets ie; disi clears it.
- Entering INT clears ie and stores the old value in ie_save.
- reti restores ie from ie_save.

Priority: the lowest-index unmasked active channel wins. The winner is latched into int_vec_o on the transition into INT.

Bus timeout:
- An 8-bit counter increments every enabled cycle spent in FETCH or MEM with the relevant ack low, and clears on ack or on a state change.
- When it reaches TIMEOUT, the machine goes to INT regardless of ie, with the trap flag set.
- In that INT cycle: bus_err_o=1, int_ack_o=0, pc_oper_o=1111, and int_vec_o is unchanged.

Output decode:
- FETCH: inst_stb_o=1, inst_cyc_o=1.
- EXECUTE: op2_o=1, alu_en_o=1 and flag_en_o=1 for arith/shift; port_we_o=1 for out.
- alu_op_o, arith func_i mapping: 000/001 -> 0001, 010/011 -> 0011, 100 -> 0010, 101 -> 0110, 110 -> 0100, 111 -> 0101.
- alu_op_o is 0000 for all non-arith instructions.
- MEM: data_stb_o=1, data_cyc_o=1; data_we_o=1 for stm.
- WRITEBACK: reg_wr_o=1; reg_mux_o as listed in the interface.
- pc_en_o: asserted in DECODE for jump, branch and ret/reti, and in WRITEBACK and INT.
- pc_oper_o:
  - branch: 01 followed by func_i[1:0].
  - jump: 1000.
  - ret/reti: 1001.
  - INT: 1010, or 1111 when trapping.
  - otherwise 0000.
- push_o: asserted for jsb in DECODE and in INT.
- pop_o: asserted for ret/reti in DECODE.
- int_o: asserted in INT.
- int_ack_o: one-hot of the latched winner during INT.

## Timing
- While rst=1: state=FETCH, ie=0, ie_save=0, counter=0, int_vec_o=0, and every output is forced to 0. state_o still reads FETCH.
- The first cycle after rst falls drives inst_stb_o and inst_cyc_o.
- rst mid-transaction aborts immediately. Strobes drop in the same cycle that rst is high.
- Minimum latencies, each counted from the FETCH ack:
  - arith: 3 cycles to FETCH (DECODE, EXECUTE, WRITEBACK).
  - ldm with zero-wait ack: 4 cycles.
  - jump: 1 cycle.
- The int_ack_o pulse is exactly one enabled cycle long.
- An irq dropping before it is sampled at the instruction boundary is not serviced.
- An ack and the timeout threshold reached in the same cycle: the ack wins.
- cen=0 freezes the state; outputs continue to reflect the held state.

## Structure
- Package gumnut_ctrl_pkg holds:
  - state enum (3 bits);
  - opcode class and func constants;
  - ALU op codes;
  - pc_oper codes.
- Sub-module gumnut_irq_prio: combinational masked priority encoder producing valid, index[IRQ_W] and one-hot[NUM_IRQ].

## Test plan
- Reset, then feed arith add (op 1110000, func 000) with inst_ack_i=1: the state sequence is FETCH, DECODE, EXECUTE, WRITEBACK, FETCH, and alu_op_o=0001 in EXECUTE.
- ldm with data_ack_i delayed 3 cycles: MEM is held for 4 cycles, then WRITEBACK with reg_mux_o=01.
- enai executed, then irq_i=0110 with mask 0000 during an arith: after WRITEBACK comes INT with int_vec_o=1 and int_ack_o=0010. After reti, ie=1 again.
- irq_i=0001 with irq_mask_i=0001 during wait: WAIT holds. Then irq_i=1000: INT with int_vec_o=3.
- Fetch with no ack, TIMEOUT=15: INT on the 16th enabled cycle with bus_err_o=1 and pc_oper_o=1111.
- rst asserted in MEM of a stm: the next cycle is FETCH, and data_stb_o and data_we_o are 0 during the rst cycle.
